// File: rtl/membus_lsu_master.sv
// Load/store initiator for the SoC data memory bus: one command at a time, byte-lane
// alignment, load extension, misalignment detection and a bus timeout.
module membus_lsu_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [1:0]  cmd_size,
  input  logic        cmd_unsigned,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_write_en,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        we_reg;
  logic        uns_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] cnt_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic        cmd_fire;
  logic        cmd_bad;
  logic        tmo_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted_rd;
  logic [31:0] load_ext;

  assign cmd_fire = cmd_valid && (state_reg == IDLE);

  always_comb begin
    cmd_bad = 1'b0;
    case (cmd_size)
      2'd1:    cmd_bad = cmd_addr[0];
      2'd2:    cmd_bad = (cmd_addr[1:0] != 2'b00);
      2'd3:    cmd_bad = 1'b1;
      default: cmd_bad = 1'b0;
    endcase
  end

  // Counter holds the number of BUS cycles already completed, so the last
  // permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  // Aligned accesses make "shift then replicate lower lanes" a plain replication.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = cmd_wdata;
    case (cmd_size)
      2'd0: begin
        be_next    = 4'b0001 << cmd_addr[1:0];
        wdata_next = {4{cmd_wdata[7:0]}};
      end
      2'd1: begin
        be_next    = 4'b0011 << cmd_addr[1:0];
        wdata_next = {2{cmd_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = cmd_wdata;
      end
    endcase
  end

  always_comb begin
    shifted_rd = bus_read_data >> {off_reg, 3'b000};
    case (size_reg)
      2'd0:    load_ext = {{24{shifted_rd[7] & ~uns_reg}}, shifted_rd[7:0]};
      2'd1:    load_ext = {{16{shifted_rd[15] & ~uns_reg}}, shifted_rd[15:0]};
      default: load_ext = shifted_rd;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = cmd_bad ? RESP : BUS;
      BUS:     if (bus_valid || tmo_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      addr_reg  <= '0;
      off_reg   <= '0;
      size_reg  <= '0;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      be_reg    <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else if (cmd_fire) begin
      addr_reg  <= {cmd_addr[31:2], 2'b00};
      off_reg   <= cmd_addr[1:0];
      size_reg  <= cmd_size;
      we_reg    <= cmd_we;
      uns_reg   <= cmd_unsigned;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= '0;
      err_reg   <= cmd_bad;
      rdata_reg <= '0;
    end else if (state_reg == BUS) begin
      cnt_reg <= cnt_reg + 32'd1;
      if (bus_valid) begin
        err_reg   <= 1'b0;
        rdata_reg <= we_reg ? 32'd0 : load_ext;
      end else if (tmo_hit) begin
        err_reg   <= 1'b1;
        rdata_reg <= '0;
      end
    end
  end

  // Bus and response fields come from registers and are gated to zero outside their state.
  assign cmd_ready      = (state_reg == IDLE);
  assign rsp_valid      = (state_reg == RESP);
  assign rsp_err        = rsp_valid & err_reg;
  assign rsp_rdata      = rsp_valid ? rdata_reg : 32'd0;
  assign bus_req        = (state_reg == BUS);
  assign bus_addr       = bus_req ? addr_reg : 32'd0;
  assign bus_write_en   = bus_req & we_reg;
  assign bus_byte_en    = bus_req ? be_reg : 4'd0;
  assign bus_write_data = bus_req ? wdata_reg : 32'd0;

endmodule

// File: tb/tb_membus_lsu_master.sv
// Randomized and directed bench for membus_lsu_master; a lane-level model sets the
// expected outputs for every cycle and one negedge process compares them.
module tb_membus_lsu_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_unsigned;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_write_en, bus_valid;
  logic [31:0] bus_addr, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_en;

  membus_lsu_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_size(cmd_size),
    .cmd_unsigned(cmd_unsigned), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_write_en(bus_write_en),
    .bus_byte_en(bus_byte_en), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic        exp_cmd_ready, exp_rsp_valid, exp_rsp_err, exp_bus_req, exp_bus_we;
  logic [31:0] exp_rsp_rdata, exp_bus_addr, exp_bus_wdata;
  logic [3:0]  exp_bus_be;

  int          nreq, nrsp;
  logic [31:0] cap_rdata, cap_addr, cap_wdata;
  logic        cap_err, cap_we;
  logic [3:0]  cap_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready",      32'(cmd_ready),    32'(exp_cmd_ready));
      chk("rsp_valid",      32'(rsp_valid),    32'(exp_rsp_valid));
      chk("rsp_err",        32'(rsp_err),      32'(exp_rsp_err));
      chk("rsp_rdata",      rsp_rdata,         exp_rsp_rdata);
      chk("bus_req",        32'(bus_req),      32'(exp_bus_req));
      chk("bus_addr",       bus_addr,          exp_bus_addr);
      chk("bus_write_en",   32'(bus_write_en), 32'(exp_bus_we));
      chk("bus_byte_en",    32'(bus_byte_en),  32'(exp_bus_be));
      chk("bus_write_data", bus_write_data,    exp_bus_wdata);
    end
  end

  // ---- behavioural model: lane arithmetic ----
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_bad(input logic [1:0] size, input logic [31:0] addr);
    int o = int'(addr[1:0]);
    return (size == 2'd3) || ((o % nbytes(size)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] be = '0;
    int o = int'(addr[1:0]);
    int n = nbytes(size);
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] w = '0;
    int n = nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v = '0;
    int o = int'(addr[1:0]);
    int n = nbytes(size);
    for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(o + j) +: 8];
    if (!uns && v[8*n - 1])
      for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // ---- driver ----
  task automatic set_exp(input logic rdy, input logic rv, input logic re, input logic [31:0] rd,
                         input logic br, input logic [31:0] ba, input logic bw,
                         input logic [3:0] bb, input logic [31:0] bd);
    exp_cmd_ready = rdy; exp_rsp_valid = rv; exp_rsp_err = re; exp_rsp_rdata = rd;
    exp_bus_req = br; exp_bus_addr = ba; exp_bus_we = bw; exp_bus_be = bb; exp_bus_wdata = bd;
  endtask

  task automatic set_idle();
    set_exp(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic step();
    @(negedge clk);
    if (bus_req) begin
      nreq++; cap_addr = bus_addr; cap_be = bus_byte_en; cap_wdata = bus_write_data; cap_we = bus_write_en;
    end
    if (rsp_valid) begin
      nrsp++; cap_rdata = rsp_rdata; cap_err = rsp_err;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_we = 1'($urandom_range(0, 1));
    cmd_size = 2'($urandom_range(0, 3));
    cmd_unsigned = 1'($urandom_range(0, 1));
    cmd_addr = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic idle_cycles(input int n, input logic force_bv);
    for (int i = 0; i < n; i++) begin
      set_idle();
      cmd_valid = 1'b0;
      bus_valid = force_bv | 1'($urandom_range(0, 1));
      bus_read_data = $urandom;
      step();
    end
  endtask

  // lat = BUS cycle carrying bus_valid (0 = slave silent); rst_at = BUS cycle with reset
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                         input logic [31:0] rd, input int rst_at, input logic stale);
    logic got, done;
    int k;
    nreq = 0; nrsp = 0;
    set_idle();
    cmd_valid = 1'b1; cmd_we = we; cmd_size = size; cmd_unsigned = uns;
    cmd_addr = addr; cmd_wdata = wdata;
    bus_valid = 1'($urandom_range(0, 1));
    bus_read_data = $urandom;
    step();
    junk_cmd();
    got = 1'b0;
    if (m_bad(size, addr)) begin
      set_exp(1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
      bus_valid = stale;
      step();
    end else begin
      done = 1'b0;
      for (k = 1; !done && k <= T; k++) begin
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, {addr[31:2], 2'b00}, we,
                m_be(size, addr), m_wdata(size, wdata));
        bus_valid = (k == lat);
        bus_read_data = (k == lat) ? rd : $urandom;
        if (k == rst_at) res = 1'b1;
        step();
        junk_cmd();
        if (k == rst_at) begin
          res = 1'b0;
          set_idle();
          cmd_valid = 1'b0;
          bus_valid = 1'b0;
          return;
        end
        if (k == lat) begin got = 1'b1; done = 1'b1; end
      end
      set_exp(1'b0, 1'b1, ~got, (got && !we) ? m_load(size, uns, addr, rd) : 32'd0,
              1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
      bus_valid = stale;
      bus_read_data = $urandom;
      step();
    end
    set_idle();
    cmd_valid = 1'b0;
    bus_valid = 1'b0;
  endtask

  initial begin
    res = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_size = 2'd0; cmd_unsigned = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; bus_valid = 1'b0; bus_read_data = '0;
    nreq = 0; nrsp = 0;
    cap_rdata = '0; cap_err = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    set_idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    step();
    res = 1'b0;
    idle_cycles(2, 1'b0);

    // word load
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd0, 3, 32'hDEAD_BEEF, 0, 1'b0);
    chk("wl_rdata", cap_rdata, 32'hDEAD_BEEF);
    chk("wl_err",   32'(cap_err), 32'd0);
    chk("wl_addr",  cap_addr, 32'h0000_1000);
    chk("wl_be",    32'(cap_be), 32'hF);
    chk("wl_nreq",  32'(nreq), 32'd3);

    // signed / unsigned byte load
    run_txn(1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'd0, 1, 32'h80FF_1234, 0, 1'b1);
    chk("bs_rdata", cap_rdata, 32'hFFFF_FF80);
    chk("bs_be",    32'(cap_be), 32'h8);
    run_txn(1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'd0, 2, 32'h80FF_1234, 0, 1'b0);
    chk("bu_rdata", cap_rdata, 32'h0000_0080);

    // half store
    run_txn(1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 2, 32'h1111_2222, 0, 1'b0);
    chk("hs_be",    32'(cap_be), 32'hC);
    chk("hs_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("hs_we",    32'(cap_we), 32'd1);
    chk("hs_rdata", cap_rdata, 32'd0);

    // misaligned word and illegal size
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'd0, 1, 32'h0, 0, 1'b1);
    chk("mis_nreq", 32'(nreq), 32'd0);
    chk("mis_err",  32'(cap_err), 32'd1);
    run_txn(1'b1, 2'd3, 1'b0, 32'h0000_4000, 32'h55, 1, 32'h0, 0, 1'b0);
    chk("sz3_nreq", 32'(nreq), 32'd0);
    chk("sz3_err",  32'(cap_err), 32'd1);

    // timeout, then a late bus_valid two cycles after it
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'd0, 0, 32'h0, 0, 1'b1);
    chk("to_nreq",  32'(nreq), 32'd4);
    chk("to_err",   32'(cap_err), 32'd1);
    chk("to_rdata", cap_rdata, 32'd0);
    idle_cycles(1, 1'b1);

    // bus_valid in the timeout cycle
    run_txn(1'b0, 2'd1, 1'b1, 32'h0000_6002, 32'd0, 4, 32'hBEEF_0000, 0, 1'b0);
    chk("tv_err",   32'(cap_err), 32'd0);
    chk("tv_rdata", cap_rdata, 32'h0000_BEEF);

    // reset in the 2nd BUS cycle, then a normal load
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'd0, 3, 32'h1, 2, 1'b0);
    idle_cycles(1, 1'b0);
    chk("rst_nrsp", 32'(nrsp), 32'd0);
    chk("rst_nreq", 32'(nreq), 32'd2);
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 2, 32'h1234_5678, 0, 1'b0);
    chk("post_rst_rdata", cap_rdata, 32'h1234_5678);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = $urandom;
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              a, $urandom, $urandom_range(1, 6), $urandom, 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3), 1'b0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
